// File: rtl/final_cpa_pipe.sv
// Segmented, pipelined carry-propagate adder that resolves the sum/carry rows of the
// multiplier tree into the final product, SEG_W columns per stage, with valid/ready flow control.
module final_cpa_pipe #(
    parameter int BITWIDTH       = 8,
    parameter int LEASTSIGNIFCOL = 0,
    parameter int SEG_W          = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [2*BITWIDTH-LEASTSIGNIFCOL-1:0]       in_row0,
    input  logic [2*BITWIDTH-LEASTSIGNIFCOL-1:0]       in_row1,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [2*BITWIDTH-1:0]                      product,
    output logic                                       cout
);
    localparam int W    = 2*BITWIDTH - LEASTSIGNIFCOL;
    localparam int NSEG = (W + SEG_W - 1) / SEG_W;

    logic [NSEG-1:0]         valid_vec_s;
    logic [NSEG:0]           ready_s;
    logic [NSEG-1:0][W-1:0]  res_vec_s;
    logic [NSEG-1:0][W-1:0]  row0_vec_s;
    logic [NSEG-1:0][W-1:0]  row1_vec_s;
    logic [NSEG-1:0]         c_vec_s;
    logic                    unused_rows_s;

    // Ready ripples back from the output; an empty stage always accepts, so bubbles compress.
    always_comb begin
        ready_s       = '0;
        ready_s[NSEG] = out_ready;
        for (int s = NSEG - 1; s >= 0; s--) begin
            ready_s[s] = !valid_vec_s[s] || ready_s[s+1];
        end
    end

    for (genvar s = 0; s < NSEG; s++) begin : g_stage
        localparam int LO = s * SEG_W;
        localparam int SW = ((W - LO) < SEG_W) ? (W - LO) : SEG_W;

        logic          up_valid_s;
        logic [W-1:0]  up_res_s;
        logic [W-1:0]  up_row0_s;
        logic [W-1:0]  up_row1_s;
        logic          up_c_s;
        logic [SW:0]   seg_sum_s;
        logic          valid_q, valid_d;
        logic [W-1:0]  res_q, res_d;
        logic [W-1:0]  row0_q, row0_d;
        logic [W-1:0]  row1_q, row1_d;
        logic          c_q, c_d;

        if (s == 0) begin : g_src
            assign up_valid_s = in_valid;
            assign up_res_s   = '0;
            assign up_row0_s  = in_row0;
            assign up_row1_s  = in_row1;
            assign up_c_s     = 1'b0;
        end else begin : g_src
            assign up_valid_s = valid_vec_s[s-1];
            assign up_res_s   = res_vec_s[s-1];
            assign up_row0_s  = row0_vec_s[s-1];
            assign up_row1_s  = row1_vec_s[s-1];
            assign up_c_s     = c_vec_s[s-1];
        end

        assign seg_sum_s = {1'b0, up_row0_s[LO +: SW]} + {1'b0, up_row1_s[LO +: SW]}
                         + {{SW{1'b0}}, up_c_s};

        // Load the upstream word with this segment resolved, or hold while stalled.
        always_comb begin
            valid_d = valid_q;
            res_d   = res_q;
            row0_d  = row0_q;
            row1_d  = row1_q;
            c_d     = c_q;
            if (ready_s[s]) begin
                valid_d           = up_valid_s;
                res_d             = up_res_s;
                res_d[LO +: SW]   = seg_sum_s[SW-1:0];
                row0_d            = up_row0_s;
                row1_d            = up_row1_s;
                c_d               = seg_sum_s[SW];
            end else begin
                valid_d = valid_q;
            end
        end

        // Stage registers; reset discards any in-flight word.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                res_q   <= '0;
                row0_q  <= '0;
                row1_q  <= '0;
                c_q     <= 1'b0;
            end else begin
                valid_q <= valid_d;
                res_q   <= res_d;
                row0_q  <= row0_d;
                row1_q  <= row1_d;
                c_q     <= c_d;
            end
        end

        assign valid_vec_s[s] = valid_q;
        assign res_vec_s[s]   = res_q;
        assign row0_vec_s[s]  = row0_q;
        assign row1_vec_s[s]  = row1_q;
        assign c_vec_s[s]     = c_q;
    end

    // The last stage's copy of the raw rows is fully consumed already.
    assign unused_rows_s = ^{row0_vec_s[NSEG-1], row1_vec_s[NSEG-1]};

    assign in_ready  = ready_s[0];
    assign out_valid = valid_vec_s[NSEG-1];
    assign cout      = c_vec_s[NSEG-1];

    // Place the resolved columns at their product position; columns below LSC are absent.
    always_comb begin
        product = '0;
        product[2*BITWIDTH-1:LEASTSIGNIFCOL] = res_vec_s[NSEG-1];
    end
endmodule

// File: tb/tb_final_cpa_pipe.sv
// Scoreboard bench for final_cpa_pipe: directed carry cases, stall/back-pressure, reset flush
// and random traffic on an LSC=0 instance, plus directed checks on an LSC=3 instance.
module tb_final_cpa_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, cout;
    logic [15:0] in_row0, in_row1, product;
    logic        in_valid3, in_ready3, out_valid3, out_ready3, cout3;
    logic [12:0] in_row0_3, in_row1_3;
    logic [15:0] product3;

    int          checks   = 0;
    int          errors   = 0;
    int          pushed_n = 0;
    logic [16:0] sb_q[$];
    logic [16:0] exp_v;
    logic        hold_chk = 1'b0;
    logic [15:0] hold_prod;
    logic        hold_cout;

    final_cpa_pipe #(.BITWIDTH(8), .LEASTSIGNIFCOL(0), .SEG_W(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_row0(in_row0), .in_row1(in_row1), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .cout(cout));

    final_cpa_pipe #(.BITWIDTH(8), .LEASTSIGNIFCOL(3), .SEG_W(4)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_row0(in_row0_3), .in_row1(in_row1_3), .out_valid(out_valid3),
        .out_ready(out_ready3), .product(product3), .cout(cout3));

    always #5 clk = ~clk;

    function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Monitor: push on input handshake, pop/compare on output handshake, check stall stability.
    always @(negedge clk) begin
        if (rst) begin
            hold_chk = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                sb_q.push_back(ref_sum(in_row0, in_row1));
                pushed_n++;
            end
            if (hold_chk) begin
                checks++;
                assert (product === hold_prod && cout === hold_cout) else begin
                    errors++;
                    $error("FAIL stall_hold: product=%h cout=%b expected product=%h cout=%b",
                           product, cout, hold_prod, hold_cout);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                assert (sb_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_out: product=%h cout=%b expected no output",
                           product, cout);
                end
                if (sb_q.size() != 0) begin
                    exp_v = sb_q.pop_front();
                    checks++;
                    assert ({cout, product} === exp_v) else begin
                        errors++;
                        $error("FAIL sb_data: got cout/product=%h expected %h",
                               {cout, product}, exp_v);
                    end
                end
            end
            hold_chk  = out_valid && !out_ready;
            hold_prod = product;
            hold_cout = cout;
        end
    end

    task automatic direct(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ep, input logic ec, input string tag);
        in_valid = 1'b1; in_row0 = a; in_row1 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        assert (out_valid === 1'b0) else begin
            errors++;
            $error("FAIL %s_early: out_valid=%b expected 0", tag, out_valid);
        end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (k < 3) begin
                assert (out_valid === 1'b0) else begin
                    errors++;
                    $error("FAIL %s_lat%0d: out_valid=%b expected 0", tag, k, out_valid);
                end
            end else begin
                assert (out_valid === 1'b1 && product === ep && cout === ec) else begin
                    errors++;
                    $error("FAIL %s: valid=%b product=%h cout=%b expected valid=1 product=%h cout=%b",
                           tag, out_valid, product, cout, ep, ec);
                end
            end
        end
    endtask

    task automatic run3(input logic [12:0] a, input logic [12:0] b,
                        input logic [15:0] ep, input logic ec, input string tag);
        in_valid3 = 1'b1; in_row0_3 = a; in_row1_3 = b;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        for (int k = 0; k < 10 && !out_valid3; k++) begin
            @(posedge clk); #1;
        end
        checks++;
        assert (out_valid3 === 1'b1 && product3 === ep && cout3 === ec) else begin
            errors++;
            $error("FAIL %s: valid=%b product=%h cout=%b expected valid=1 product=%h cout=%b",
                   tag, out_valid3, product3, cout3, ep, ec);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && sb_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL %s_drain: %0d results outstanding expected 0", tag, sb_q.size());
        end
    endtask

    initial begin
        int sent;
        int start_n;
        int seen;
        logic fell_seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_row0 = '0; in_row1 = '0;
        in_valid3 = 1'b0; out_ready3 = 1'b1; in_row0_3 = '0; in_row1_3 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        checks++;
        assert (out_valid === 1'b0 && product === 16'h0000 && cout === 1'b0 && in_ready === 1'b1)
        else begin
            errors++;
            $error("FAIL reset_state: valid=%b product=%h cout=%b in_ready=%b expected 0/0000/0/1",
                   out_valid, product, cout, in_ready);
        end

        direct(16'h00FF, 16'h0001, 16'h0100, 1'b0, "add_00ff");
        direct(16'hFFFF, 16'h0001, 16'h0000, 1'b1, "ripple_ffff");
        direct(16'h8421, 16'h7BDE, 16'hFFFF, 1'b0, "no_carry");
        drain("directed");

        run3(13'h1FFF, 13'h0001, 16'h0000, 1'b1, "lsc3_wrap");
        run3(13'h0010, 13'h0008, 16'h00C0, 1'b0, "lsc3_shift");
        run3(13'h1000, 13'h0FFF, 16'hFFF8, 1'b0, "lsc3_top");

        // Back-to-back 8 inputs with output stalled during cycles 3..7.
        sent = 0; fell_seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            out_ready = !(c >= 3 && c <= 7);
            in_valid  = (sent < 8);
            in_row0   = 16'(sent * 16'h1111);
            in_row1   = 16'hF0F0 ^ 16'(sent);
            @(negedge clk);
            if (in_valid && !in_ready && !fell_seen) begin
                fell_seen = 1'b1;
                checks++;
                assert (sent == 4) else begin
                    errors++;
                    $error("FAIL in_ready_fall: accepted=%0d expected 4", sent);
                end
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            if (sent == 8 && c >= 8) break;
        end
        checks++;
        assert (fell_seen && sent == 8) else begin
            errors++;
            $error("FAIL backpressure: fell=%b sent=%0d expected fell=1 sent=8", fell_seen, sent);
        end
        drain("backpressure");

        // Reset with three transactions in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_row0 = 16'h0F00 + 16'(k); in_row1 = 16'h00F0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        assert (out_valid === 1'b1) else begin
            errors++;
            $error("FAIL preflush_valid: out_valid=%b expected 1", out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        assert (out_valid === 1'b0 && product === 16'h0000 && cout === 1'b0) else begin
            errors++;
            $error("FAIL rst_async: valid=%b product=%h cout=%b expected 0/0000/0",
                   out_valid, product, cout);
        end
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        assert (seen == 0 && in_ready === 1'b1) else begin
            errors++;
            $error("FAIL stale_out: outputs=%0d in_ready=%b expected 0 outputs in_ready=1",
                   seen, in_ready);
        end

        // Random traffic with random back-pressure.
        start_n = pushed_n;
        for (int c = 0; c < 40000 && (pushed_n - start_n) < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_row0   = 16'($urandom);
            in_row1   = 16'($urandom);
            @(posedge clk); #1;
        end
        checks++;
        assert ((pushed_n - start_n) >= 10000) else begin
            errors++;
            $error("FAIL random_budget: accepted=%0d expected 10000", pushed_n - start_n);
        end
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
